// File: rtl/dcache_data_read_sched_if.sv
// rtl/dcache_data_read_sched_if.sv - requester, issue-stage and boost signals of the dcache data read scheduler
interface dcache_data_read_sched_if #(
  parameter int ADDR_W = 12,
  parameter int WAYS   = 8
);
  logic              in0_valid;
  logic              in0_ready;
  logic [WAYS-1:0]   in0_way_en;
  logic [ADDR_W-1:0] in0_addr;

  logic              in1_valid;
  logic              in1_ready;
  logic [WAYS-1:0]   in1_way_en;
  logic [ADDR_W-1:0] in1_addr;

  logic              in2_valid;
  logic              in2_ready;
  logic [ADDR_W-1:0] in2_addr_0;
  logic [ADDR_W-1:0] in2_addr_1;
  logic              in2_valid_0;
  logic              in2_valid_1;

  logic              out_valid;
  logic              out_ready;
  logic [WAYS-1:0]   out_way_en_0;
  logic [WAYS-1:0]   out_way_en_1;
  logic [ADDR_W-1:0] out_addr_0;
  logic [ADDR_W-1:0] out_addr_1;
  logic              out_valid_0;
  logic              out_valid_1;
  logic [1:0]        out_src;
  logic              starve_boost;

  // Requesters and the data array sit on the master side.
  modport master (
    output in0_valid, in0_way_en, in0_addr,
    output in1_valid, in1_way_en, in1_addr,
    output in2_valid, in2_addr_0, in2_addr_1, in2_valid_0, in2_valid_1,
    output out_ready,
    input  in0_ready, in1_ready, in2_ready,
    input  out_valid, out_way_en_0, out_way_en_1, out_addr_0, out_addr_1,
    input  out_valid_0, out_valid_1, out_src, starve_boost
  );

  modport slave (
    input  in0_valid, in0_way_en, in0_addr,
    input  in1_valid, in1_way_en, in1_addr,
    input  in2_valid, in2_addr_0, in2_addr_1, in2_valid_0, in2_valid_1,
    input  out_ready,
    output in0_ready, in1_ready, in2_ready,
    output out_valid, out_way_en_0, out_way_en_1, out_addr_0, out_addr_1,
    output out_valid_0, out_valid_1, out_src, starve_boost
  );
endinterface

// File: rtl/dcache_data_read_sched.sv
// rtl/dcache_data_read_sched.sv - fixed-priority read-port scheduler with anti-starvation and bank-conflict split
module dcache_data_read_sched #(
  parameter int ADDR_W       = 12,
  parameter int WAYS         = 8,
  parameter int NBANKS       = 4,
  parameter int BANK_LSB     = 3,
  parameter int STARVE_LIMIT = 15
) (
  input logic                    clock,
  input logic                    reset,
  dcache_data_read_sched_if.slave bus
);
  localparam int BANK_W = $clog2(NBANKS);
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [WAYS-1:0]  ALL_WAYS = {WAYS{1'b1}};

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              out_valid_q;
  logic [1:0]        out_src_q;
  logic              out_v0_q, out_v1_q;
  logic [ADDR_W-1:0] out_a0_q, out_a1_q;
  logic [WAYS-1:0]   out_w0_q, out_w1_q;

  logic              nxt_valid;
  logic [1:0]        nxt_src;
  logic              nxt_v0, nxt_v1;
  logic [ADDR_W-1:0] nxt_a0, nxt_a1;
  logic [WAYS-1:0]   nxt_w0, nxt_w1;

  logic              load;
  logic              boost;
  logic              conflict;
  logic              pick0, pick1, pick2;
  logic              ready0, ready1, ready2;

  assign load  = !out_valid_q | bus.out_ready;
  assign boost = (cnt_q == CNT_MAX);

  // Distinct addresses in the same bank cannot be read in one array access.
  assign conflict = bus.in2_valid_0 & bus.in2_valid_1 &
                    (bus.in2_addr_0[BANK_LSB +: BANK_W] == bus.in2_addr_1[BANK_LSB +: BANK_W]) &
                    (bus.in2_addr_0 != bus.in2_addr_1);

  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    pick2 = 1'b0;
    if (state_q == SPLIT) begin
      pick2 = 1'b1;
    end else if (boost && bus.in2_valid) begin
      pick2 = 1'b1;
    end else if (bus.in0_valid) begin
      pick0 = 1'b1;
    end else if (bus.in1_valid) begin
      pick1 = 1'b1;
    end else if (bus.in2_valid) begin
      pick2 = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready0    = 1'b0;
    ready1    = 1'b0;
    ready2    = 1'b0;
    nxt_valid = 1'b0;
    nxt_src   = 2'd0;
    nxt_v0    = 1'b0;
    nxt_v1    = 1'b0;
    nxt_a0    = '0;
    nxt_a1    = '0;
    nxt_w0    = '0;
    nxt_w1    = '0;

    if (pick0) begin
      ready0    = load;
      nxt_valid = 1'b1;
      nxt_src   = 2'd0;
      nxt_v0    = 1'b1;
      nxt_a0    = bus.in0_addr;
      nxt_w0    = bus.in0_way_en;
    end else if (pick1) begin
      ready1    = load;
      nxt_valid = 1'b1;
      nxt_src   = 2'd1;
      nxt_v0    = 1'b1;
      nxt_a0    = bus.in1_addr;
      nxt_w0    = bus.in1_way_en;
    end else if (pick2) begin
      nxt_src = 2'd2;
      if (state_q == SPLIT) begin
        // Second half: lane 1 keeps its own lane position.
        ready2    = load;
        nxt_valid = 1'b1;
        nxt_v1    = 1'b1;
        nxt_a1    = bus.in2_addr_1;
        nxt_w1    = ALL_WAYS;
        if (load) state_d = IDLE;
      end else if (conflict) begin
        nxt_valid = 1'b1;
        nxt_v0    = 1'b1;
        nxt_a0    = bus.in2_addr_0;
        nxt_w0    = ALL_WAYS;
        if (load) state_d = SPLIT;
      end else begin
        ready2    = load;
        nxt_valid = bus.in2_valid_0 | bus.in2_valid_1;
        nxt_v0    = bus.in2_valid_0;
        nxt_v1    = bus.in2_valid_1;
        nxt_a0    = bus.in2_valid_0 ? bus.in2_addr_0 : '0;
        nxt_a1    = bus.in2_valid_1 ? bus.in2_addr_1 : '0;
        nxt_w0    = bus.in2_valid_0 ? ALL_WAYS : '0;
        nxt_w1    = bus.in2_valid_1 ? ALL_WAYS : '0;
      end
    end

    // Stalled cycles (load = 0) also count as passing requester 2 over.
    if (!bus.in2_valid || (pick2 && load)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_src_q   <= 2'd0;
      out_v0_q    <= 1'b0;
      out_v1_q    <= 1'b0;
      out_a0_q    <= '0;
      out_a1_q    <= '0;
      out_w0_q    <= '0;
      out_w1_q    <= '0;
    end else if (load) begin
      out_valid_q <= nxt_valid;
      out_src_q   <= nxt_src;
      out_v0_q    <= nxt_v0;
      out_v1_q    <= nxt_v1;
      out_a0_q    <= nxt_a0;
      out_a1_q    <= nxt_a1;
      out_w0_q    <= nxt_w0;
      out_w1_q    <= nxt_w1;
    end
  end

  assign bus.in0_ready    = ready0;
  assign bus.in1_ready    = ready1;
  assign bus.in2_ready    = ready2;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_src      = out_src_q;
  assign bus.out_valid_0  = out_v0_q;
  assign bus.out_valid_1  = out_v1_q;
  assign bus.out_addr_0   = out_a0_q;
  assign bus.out_addr_1   = out_a1_q;
  assign bus.out_way_en_0 = out_w0_q;
  assign bus.out_way_en_1 = out_w1_q;
  assign bus.starve_boost = boost;
endmodule

// File: tb/tb_dcache_data_read_sched.sv
// tb/tb_dcache_data_read_sched.sv - scoreboard bench for dcache_data_read_sched
module tb_dcache_data_read_sched;
  localparam int ADDR_W = 12;
  localparam int WAYS   = 8;

  logic clock;
  logic reset;

  dcache_data_read_sched_if #(.ADDR_W(ADDR_W), .WAYS(WAYS)) bus ();

  dcache_data_read_sched #(
    .ADDR_W(ADDR_W), .WAYS(WAYS), .NBANKS(4), .BANK_LSB(3), .STARVE_LIMIT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]        src;
    logic              v0;
    logic [ADDR_W-1:0] a0;
    logic [WAYS-1:0]   w0;
    logic              v1;
    logic [ADDR_W-1:0] a1;
    logic [WAYS-1:0]   w1;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] src,
                      input logic v0, input logic [ADDR_W-1:0] a0, input logic [WAYS-1:0] w0,
                      input logic v1, input logic [ADDR_W-1:0] a1, input logic [WAYS-1:0] w1);
    exp_t e;
    e.src = src; e.v0 = v0; e.a0 = a0; e.w0 = w0; e.v1 = v1; e.a1 = a1; e.w1 = w1;
    exp_q.push_back(e);
  endtask

  task automatic set_in0(input logic v, input logic [ADDR_W-1:0] a, input logic [WAYS-1:0] w);
    bus.in0_valid = v; bus.in0_addr = a; bus.in0_way_en = w;
  endtask

  task automatic set_in1(input logic v, input logic [ADDR_W-1:0] a, input logic [WAYS-1:0] w);
    bus.in1_valid = v; bus.in1_addr = a; bus.in1_way_en = w;
  endtask

  task automatic set_in2(input logic v, input logic v0, input logic [ADDR_W-1:0] a0,
                         input logic v1, input logic [ADDR_W-1:0] a1);
    bus.in2_valid = v; bus.in2_valid_0 = v0; bus.in2_addr_0 = a0;
    bus.in2_valid_1 = v1; bus.in2_addr_1 = a1;
  endtask

  // One clock: readies/boost checked on the falling edge, inputs change 1 after the rising edge.
  task automatic cyc(input string tag, input logic e0, input logic e1, input logic e2, input logic eb);
    @(negedge clock);
    chk({tag, " in0_ready"}, 32'(bus.in0_ready), 32'(e0));
    chk({tag, " in1_ready"}, 32'(bus.in1_ready), 32'(e1));
    chk({tag, " in2_ready"}, 32'(bus.in2_ready), 32'(e2));
    chk({tag, " starve_boost"}, 32'(bus.starve_boost), 32'(eb));
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected: got src=%0d addr_0=0x%0h addr_1=0x%0h expected no issue",
                 bus.out_src, bus.out_addr_0, bus.out_addr_1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue out_src",      32'(bus.out_src),      32'(e.src));
        chk("issue out_valid_0",  32'(bus.out_valid_0),  32'(e.v0));
        chk("issue out_addr_0",   32'(bus.out_addr_0),   32'(e.a0));
        chk("issue out_way_en_0", 32'(bus.out_way_en_0), 32'(e.w0));
        chk("issue out_valid_1",  32'(bus.out_valid_1),  32'(e.v1));
        chk("issue out_addr_1",   32'(bus.out_addr_1),   32'(e.a1));
        chk("issue out_way_en_1", 32'(bus.out_way_en_1), 32'(e.w1));
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.out_ready = 1'b0;
    set_in0(0, '0, '0);
    set_in1(0, '0, '0);
    set_in2(0, 0, '0, 0, '0);
    repeat (2) @(posedge clock);
    #1;
    chk("reset out_valid",    32'(bus.out_valid),    32'd0);
    chk("reset out_valid_0",  32'(bus.out_valid_0),  32'd0);
    chk("reset out_addr_0",   32'(bus.out_addr_0),   32'd0);
    chk("reset out_way_en_1", 32'(bus.out_way_en_1), 32'd0);
    chk("reset out_src",      32'(bus.out_src),      32'd0);
    chk("reset starve_boost", 32'(bus.starve_boost), 32'd0);
    chk("reset in0_ready",    32'(bus.in0_ready),    32'd0);
    reset = 1'b1;
    bus.out_ready = 1'b1;

    // Priority 0 > 1 > 2.
    set_in0(1, 12'h100, 8'h01);
    set_in1(1, 12'h120, 8'h02);
    set_in2(1, 1, 12'h010, 1, 12'h018);
    push(2'd0, 1, 12'h100, 8'h01, 0, '0, '0);
    cyc("prio_in0", 1, 0, 0, 0);
    set_in0(0, '0, '0);
    push(2'd1, 1, 12'h120, 8'h02, 0, '0, '0);
    cyc("prio_in1", 0, 1, 0, 0);
    set_in1(0, '0, '0);
    push(2'd2, 1, 12'h010, 8'hFF, 1, 12'h018, 8'hFF);
    cyc("prio_in2", 0, 0, 1, 0);
    set_in2(0, 0, '0, 0, '0);
    cyc("prio_idle", 0, 0, 0, 0);

    // Same-bank split, with in0 arriving while requester 2 is locked.
    set_in2(1, 1, 12'h010, 1, 12'h210);
    push(2'd2, 1, 12'h010, 8'hFF, 0, '0, '0);
    cyc("split_first", 0, 0, 0, 0);
    set_in0(1, 12'h140, 8'h04);
    push(2'd2, 0, '0, '0, 1, 12'h210, 8'hFF);
    cyc("split_second", 0, 0, 1, 0);
    set_in2(0, 0, '0, 0, '0);
    push(2'd0, 1, 12'h140, 8'h04, 0, '0, '0);
    cyc("split_after", 1, 0, 0, 0);
    set_in0(0, '0, '0);

    // No conflict: different banks, then identical addresses, then lane 1 only, then no lanes.
    set_in2(1, 1, 12'h010, 1, 12'h018);
    push(2'd2, 1, 12'h010, 8'hFF, 1, 12'h018, 8'hFF);
    cyc("nocf_banks", 0, 0, 1, 0);
    set_in2(1, 1, 12'h010, 1, 12'h010);
    push(2'd2, 1, 12'h010, 8'hFF, 1, 12'h010, 8'hFF);
    cyc("nocf_same", 0, 0, 1, 0);
    set_in2(1, 0, 12'h3AB, 1, 12'h055);
    push(2'd2, 0, '0, '0, 1, 12'h055, 8'hFF);
    cyc("lane1_only", 0, 0, 1, 0);
    set_in2(1, 0, 12'h123, 0, 12'h456);
    cyc("in2_empty", 0, 0, 1, 0);
    set_in2(0, 0, '0, 0, '0);
    cyc("empty_idle", 0, 0, 0, 0);

    // Starvation: 15 passed-over cycles, then requester 2 is boosted.
    set_in2(1, 1, 12'h020, 1, 12'h028);
    for (int k = 0; k < 15; k++) begin
      set_in0(1, 12'(12'h200 + k), 8'h10);
      push(2'd0, 1, 12'(12'h200 + k), 8'h10, 0, '0, '0);
      cyc("starve_pass", 1, 0, 0, 0);
    end
    set_in0(1, 12'h20F, 8'h10);
    push(2'd2, 1, 12'h020, 8'hFF, 1, 12'h028, 8'hFF);
    cyc("starve_boost", 0, 0, 1, 1);
    set_in2(0, 0, '0, 0, '0);
    push(2'd0, 1, 12'h20F, 8'h10, 0, '0, '0);
    cyc("starve_after", 1, 0, 0, 0);
    set_in0(0, '0, '0);
    cyc("starve_idle", 0, 0, 0, 0);

    // Back-pressure for 5 cycles, then drain plus load in the same cycle.
    bus.out_ready = 1'b0;
    set_in0(1, 12'h333, 8'h80);
    push(2'd0, 1, 12'h333, 8'h80, 0, '0, '0);
    cyc("bp_load", 1, 0, 0, 0);
    set_in0(0, '0, '0);
    set_in1(1, 12'h344, 8'h40);
    for (int k = 0; k < 5; k++) begin
      cyc("bp_hold", 0, 0, 0, 0);
      chk("bp out_valid",    32'(bus.out_valid),    32'd1);
      chk("bp out_addr_0",   32'(bus.out_addr_0),   32'h333);
      chk("bp out_way_en_0", 32'(bus.out_way_en_0), 32'h80);
      chk("bp out_src",      32'(bus.out_src),      32'd0);
    end
    bus.out_ready = 1'b1;
    push(2'd1, 1, 12'h344, 8'h40, 0, '0, '0);
    cyc("bp_drain_load", 0, 1, 0, 0);
    set_in1(0, '0, '0);
    cyc("bp_drain", 0, 0, 0, 0);

    // Reset during SPLIT drops the half-issued request.
    set_in2(1, 1, 12'h010, 1, 12'h210);
    cyc("rst_split_first", 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    #1;
    reset = 1'b0;
    set_in2(0, 0, '0, 0, '0);
    #1;
    chk("rst out_valid",    32'(bus.out_valid),    32'd0);
    chk("rst out_valid_0",  32'(bus.out_valid_0),  32'd0);
    chk("rst starve_boost", 32'(bus.starve_boost), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    set_in0(1, 12'h3C0, 8'h08);
    push(2'd0, 1, 12'h3C0, 8'h08, 0, '0, '0);
    cyc("rst_after_in0", 1, 0, 0, 0);
    set_in0(0, '0, '0);
    cyc("final_idle0", 0, 0, 0, 0);
    cyc("final_idle1", 0, 0, 0, 0);

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
